// File: rtl/interrupt_responder_pkg.sv
// Shared TLX interrupt definitions: command/response opcodes, response codes,
// configuration modes, responder FSM states and the response-code decision.
package interrupt_responder_pkg;

   localparam logic [7:0] OP_INTRP_REQ     = 8'h58;
   localparam logic [7:0] OP_INTRP_REQ_S   = 8'h59;
   localparam logic [7:0] OP_INTRP_REQ_D   = 8'h5A;
   localparam logic [7:0] OP_INTRP_REQ_D_S = 8'h5B;
   localparam logic [7:0] OP_INTRP_RESP    = 8'h0C;
   localparam logic [7:0] OP_INTRP_RDY     = 8'h1A;

   typedef enum logic [3:0] {
      CODE_DONE    = 4'h0,
      CODE_RETRY   = 4'h2,
      CODE_PENDING = 4'h4,
      CODE_FAIL    = 4'hE
   } rsp_code_e;

   typedef enum logic [1:0] {
      MODE_DONE    = 2'd0,
      MODE_RETRY   = 2'd1,
      MODE_PENDING = 2'd2,
      MODE_FAIL    = 2'd3
   } cfg_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DELAY     = 3'd1,
      ST_SEND_RSP  = 3'd2,
      ST_PEND_WAIT = 3'd3,
      ST_SEND_RDY  = 3'd4
   } state_e;

   function automatic logic is_intrp_req(input logic [7:0] op);
      logic ok;
      case (op)
         OP_INTRP_REQ, OP_INTRP_REQ_S, OP_INTRP_REQ_D, OP_INTRP_REQ_D_S: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // A done answer turns into a busy retry while the host still owns the last interrupt.
   function automatic rsp_code_e pick_code(input cfg_mode_e mode,
                                           input logic      retry_exhausted,
                                           input logic      pending_served,
                                           input logic      host_busy);
      rsp_code_e code;
      case (mode)
         MODE_DONE:    code = CODE_DONE;
         MODE_RETRY:   code = retry_exhausted ? CODE_DONE : CODE_RETRY;
         MODE_PENDING: code = pending_served ? CODE_DONE : CODE_PENDING;
         MODE_FAIL:    code = CODE_FAIL;
         default:      code = CODE_FAIL;
      endcase
      if (code == CODE_DONE && host_busy) code = CODE_RETRY;
      return code;
   endfunction

endpackage

// File: rtl/interrupt_responder_if.sv
// AFU command / TLX response / host interrupt bundle between an AFU-side master
// and the interrupt responder (slave).
interface interrupt_responder_if;

   logic        afu_cmd_valid;
   logic [7:0]  afu_cmd_opcode;
   logic [15:0] afu_cmd_afutag;
   logic [67:0] afu_cmd_obj;

   logic        rsp_valid;
   logic [7:0]  rsp_opcode;
   logic [15:0] rsp_afutag;
   logic [3:0]  rsp_code;

   logic        host_int_valid;
   logic [63:0] host_int_src;
   logic        host_int_ack;

   modport master (
      output afu_cmd_valid, afu_cmd_opcode, afu_cmd_afutag, afu_cmd_obj, host_int_ack,
      input  rsp_valid, rsp_opcode, rsp_afutag, rsp_code, host_int_valid, host_int_src
   );

   modport slave (
      input  afu_cmd_valid, afu_cmd_opcode, afu_cmd_afutag, afu_cmd_obj, host_int_ack,
      output rsp_valid, rsp_opcode, rsp_afutag, rsp_code, host_int_valid, host_int_src
   );

endinterface

// File: rtl/intrp_delay_cnt.sv
// 16-bit loadable down-counter with zero flag; shared by the response delay
// and the pending-to-ready wait of the interrupt responder.
module intrp_delay_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        dec,
   output logic        zero
);

   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (!rst_n)                      cnt_q <= '0;
      else if (load)                   cnt_q <= load_val;
      else if (dec && cnt_q != 16'd0)  cnt_q <= cnt_q - 16'd1;
   end

   assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/interrupt_responder.sv
// TLX interrupt responder: answers AFU intrp_req commands with configurable
// delay and code, and raises the host interrupt on done.
// Define INTERRUPT_RESPONDER_STATS_EN to build the request/retry counters.
module interrupt_responder
   import interrupt_responder_pkg::*;
#(
   parameter int unsigned RETRY_COUNT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   interrupt_responder_if.slave bus,
   input  logic [1:0]           cfg_mode,
   input  logic [7:0]           cfg_rsp_delay,
   input  logic [15:0]          cfg_rdy_delay,
   output logic                 err_bad_opcode,
   output logic                 err_overlap,
   output logic [15:0]          stat_req_cnt,
   output logic [15:0]          stat_retry_cnt
);

   localparam logic [3:0] RETRY_MAX = 4'(RETRY_COUNT);

   state_e      state, state_nxt;
   logic        cmd_ok, accept;
   logic        cnt_load, cnt_dec, cnt_zero;
   logic [15:0] cnt_load_val;
   logic        fire_rsp, fire_rdy;
   rsp_code_e   code_sel;

   logic [15:0] tag_q;
   logic [63:0] obj_q;
   cfg_mode_e   mode_q;
   logic [15:0] rdy_delay_q;
   logic [3:0]  retry_cnt_q;
   logic        pending_served_q;

   // The top nibble of the object handle carries no interrupt source bits.
   logic unused_obj_hi;
   assign unused_obj_hi = ^bus.afu_cmd_obj[67:64];

   assign cmd_ok   = bus.afu_cmd_valid && is_intrp_req(bus.afu_cmd_opcode);
   assign accept   = cmd_ok && (state == ST_IDLE);
   assign code_sel = pick_code(mode_q, retry_cnt_q >= RETRY_MAX, pending_served_q,
                               bus.host_int_valid);

   intrp_delay_cnt u_delay_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      state_nxt = state;
      case (state)
         ST_IDLE:      if (accept)   state_nxt = ST_DELAY;
         ST_DELAY:     if (cnt_zero) state_nxt = ST_SEND_RSP;
         ST_SEND_RSP:  state_nxt = (bus.rsp_code == CODE_PENDING) ? ST_PEND_WAIT : ST_IDLE;
         ST_PEND_WAIT: if (cnt_zero) state_nxt = ST_SEND_RDY;
         ST_SEND_RDY:  state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Response registers load on the edge entering SEND_RSP/SEND_RDY, so the
   // pulse coincides with those states. PEND_WAIT lasts max(1, rdy_delay) cycles.
   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      fire_rsp     = 1'b0;
      fire_rdy     = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_load     = accept;
            cnt_load_val = {8'h00, cfg_rsp_delay};
         end
         ST_DELAY: begin
            cnt_dec  = 1'b1;
            fire_rsp = cnt_zero;
         end
         ST_SEND_RSP: begin
            cnt_load     = 1'b1;
            cnt_load_val = (rdy_delay_q == 16'd0) ? 16'd0 : rdy_delay_q - 16'd1;
         end
         ST_PEND_WAIT: begin
            cnt_dec  = 1'b1;
            fire_rdy = cnt_zero;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q       <= '0;
         obj_q       <= '0;
         mode_q      <= MODE_DONE;
         rdy_delay_q <= '0;
      end else if (accept) begin
         tag_q       <= bus.afu_cmd_afutag;
         obj_q       <= bus.afu_cmd_obj[63:0];
         mode_q      <= cfg_mode_e'(cfg_mode);
         rdy_delay_q <= cfg_rdy_delay;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid  <= 1'b0;
         bus.rsp_opcode <= '0;
         bus.rsp_afutag <= '0;
         bus.rsp_code   <= '0;
      end else begin
         bus.rsp_valid <= fire_rsp || fire_rdy;
         if (fire_rsp) begin
            bus.rsp_opcode <= OP_INTRP_RESP;
            bus.rsp_afutag <= tag_q;
            bus.rsp_code   <= code_sel;
         end else if (fire_rdy) begin
            bus.rsp_opcode <= OP_INTRP_RDY;
            bus.rsp_afutag <= tag_q;
            bus.rsp_code   <= CODE_DONE;
         end
      end
   end

   // A done code is only chosen while the host is idle, so set and ack never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.host_int_valid <= 1'b0;
         bus.host_int_src   <= '0;
      end else if (fire_rsp && code_sel == CODE_DONE) begin
         bus.host_int_valid <= 1'b1;
         bus.host_int_src   <= obj_q;
      end else if (bus.host_int_valid && bus.host_int_ack) begin
         bus.host_int_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt_q      <= '0;
         pending_served_q <= 1'b0;
      end else begin
         if (fire_rsp) begin
            case (code_sel)
               CODE_RETRY: if (retry_cnt_q != 4'hF) retry_cnt_q <= retry_cnt_q + 4'd1;
               CODE_DONE, CODE_FAIL: begin
                  retry_cnt_q      <= '0;
                  pending_served_q <= 1'b0;
               end
               default: ;
            endcase
         end
         if (fire_rdy) pending_served_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_bad_opcode <= 1'b0;
         err_overlap    <= 1'b0;
      end else begin
         if (bus.afu_cmd_valid && !is_intrp_req(bus.afu_cmd_opcode)) err_bad_opcode <= 1'b1;
         if (cmd_ok && state != ST_IDLE)                             err_overlap    <= 1'b1;
      end
   end

`ifdef INTERRUPT_RESPONDER_STATS_EN
   logic [15:0] req_cnt_q, retry_stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt_q    <= '0;
         retry_stat_q <= '0;
      end else begin
         if (accept && req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
         if (fire_rsp && code_sel == CODE_RETRY && retry_stat_q != 16'hFFFF)
            retry_stat_q <= retry_stat_q + 16'd1;
      end
   end

   assign stat_req_cnt   = req_cnt_q;
   assign stat_retry_cnt = retry_stat_q;
`else
   assign stat_req_cnt   = '0;
   assign stat_retry_cnt = '0;
`endif

endmodule

// File: tb/tb_interrupt_responder.sv
// Randomized scoreboard bench for interrupt_responder: stimulus predicts
// responses from a behavioural model, a negedge monitor pops and compares.
module tb_interrupt_responder;

   localparam int RC = 2;

   typedef struct {
      int          cyc;
      logic [7:0]  op;
      logic [15:0] tag;
      logic [3:0]  code;
      logic        hv;
      logic [63:0] hsrc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  cfg_mode = '0;
   logic [7:0]  cfg_rsp_delay = '0;
   logic [15:0] cfg_rdy_delay = '0;
   logic        err_bad_opcode, err_overlap;
   logic [15:0] stat_req_cnt, stat_retry_cnt;

   interrupt_responder_if bus ();

   interrupt_responder #(.RETRY_COUNT(RC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .cfg_mode       (cfg_mode),
      .cfg_rsp_delay  (cfg_rsp_delay),
      .cfg_rdy_delay  (cfg_rdy_delay),
      .err_bad_opcode (err_bad_opcode),
      .err_overlap    (err_overlap),
      .stat_req_cnt   (stat_req_cnt),
      .stat_retry_cnt (stat_retry_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];

   // Reference model state
   int          m_retries = 0;
   bit          m_pend_served = 0;
   bit          m_host_valid = 0;
   logic [63:0] m_host_src = '0;
   int          m_req_cnt = 0;
   int          m_retry_stat = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_retries = 0; m_pend_served = 0; m_host_valid = 0; m_host_src = '0;
      m_req_cnt = 0; m_retry_stat = 0;
      exp_q.delete();
   endtask

   // Monitor: every response pulse must match the oldest prediction.
   bit prev_rv = 0;
   always @(negedge clk) begin
      if (bus.rsp_valid) begin
         exp_t e;
         check("rsp_back_to_back", 64'(prev_rv), 64'd0);
         check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_cycle",  64'(cyc), 64'(e.cyc));
            check("rsp_opcode", 64'(bus.rsp_opcode), 64'(e.op));
            check("rsp_afutag", 64'(bus.rsp_afutag), 64'(e.tag));
            check("rsp_code",   64'(bus.rsp_code), 64'(e.code));
            check("host_valid_at_rsp", 64'(bus.host_int_valid), 64'(e.hv));
            check("host_src_at_rsp",   bus.host_int_src, e.hsrc);
         end
      end
      prev_rv = bus.rsp_valid;
   end

   task automatic issue(input int mode, input int d, input int rdy, input logic [7:0] op,
                        input logic [15:0] tag, input logic [67:0] obj);
      exp_t e;
      logic [3:0] code;
      @(posedge clk); #1;
      cfg_mode = 2'(mode); cfg_rsp_delay = 8'(d); cfg_rdy_delay = 16'(rdy);
      bus.afu_cmd_valid = 1'b1; bus.afu_cmd_opcode = op;
      bus.afu_cmd_afutag = tag; bus.afu_cmd_obj = obj;
      case (mode)
         0:       code = 4'h0;
         1:       code = (m_retries < RC) ? 4'h2 : 4'h0;
         2:       code = m_pend_served ? 4'h0 : 4'h4;
         default: code = 4'hE;
      endcase
      if (code == 4'h0 && m_host_valid) code = 4'h2;
      if (m_req_cnt < 16'hFFFF) m_req_cnt++;
      if (code == 4'h2) begin
         if (m_retries < 15) m_retries++;
         if (m_retry_stat < 16'hFFFF) m_retry_stat++;
      end
      if (code == 4'h0) begin m_host_valid = 1; m_host_src = obj[63:0]; end
      if (code == 4'h0 || code == 4'hE) begin m_retries = 0; m_pend_served = 0; end
      e.cyc = cyc + 2 + d; e.op = 8'h0C; e.tag = tag; e.code = code;
      e.hv = m_host_valid; e.hsrc = m_host_src;
      exp_q.push_back(e);
      if (code == 4'h4) begin
         e.cyc = e.cyc + ((rdy == 0) ? 1 : rdy) + 1;
         e.op = 8'h1A; e.code = 4'h0;
         exp_q.push_back(e);
         m_pend_served = 1;
      end
      @(posedge clk); #1;
      bus.afu_cmd_valid = 1'b0;
      // Mid-transaction cfg churn must not affect the accepted command.
      cfg_mode = 2'($urandom); cfg_rsp_delay = 8'($urandom); cfg_rdy_delay = 16'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
      check("rsp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic ack_host();
      @(posedge clk); #1 bus.host_int_ack = 1'b1;
      @(posedge clk); #1 bus.host_int_ack = 1'b0;
      m_host_valid = 0;
      check("host_cleared_after_ack", 64'(bus.host_int_valid), 64'd0);
   endtask

   task automatic check_stats(input string name);
`ifdef INTERRUPT_RESPONDER_STATS_EN
      check({name, "_req_cnt"},   64'(stat_req_cnt),   64'(m_req_cnt));
      check({name, "_retry_cnt"}, 64'(stat_retry_cnt), 64'(m_retry_stat));
`else
      check({name, "_req_cnt"},   64'(stat_req_cnt),   64'd0);
      check({name, "_retry_cnt"}, 64'(stat_retry_cnt), 64'd0);
`endif
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rsp_valid"},  64'(bus.rsp_valid), 64'd0);
      check({name, "_rsp_opcode"}, 64'(bus.rsp_opcode), 64'd0);
      check({name, "_rsp_afutag"}, 64'(bus.rsp_afutag), 64'd0);
      check({name, "_rsp_code"},   64'(bus.rsp_code), 64'd0);
      check({name, "_host_valid"}, 64'(bus.host_int_valid), 64'd0);
      check({name, "_host_src"},   bus.host_int_src, 64'd0);
      check({name, "_err_bad"},    64'(err_bad_opcode), 64'd0);
      check({name, "_err_ovl"},    64'(err_overlap), 64'd0);
      check({name, "_stat_req"},   64'(stat_req_cnt), 64'd0);
      check({name, "_stat_retry"}, 64'(stat_retry_cnt), 64'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.afu_cmd_valid = 1'b0; bus.afu_cmd_opcode = '0; bus.afu_cmd_afutag = '0;
      bus.afu_cmd_obj = '0; bus.host_int_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Mode 0, delay 3: response five cycles after the command, host src held until ack
      issue(0, 3, 0, 8'h58, 16'hC000, 68'h1234);
      wait_done();
      for (int i = 0; i < 3; i++) begin
         check("host_held_valid", 64'(bus.host_int_valid), 64'd1);
         check("host_held_src", bus.host_int_src, 64'h1234);
         @(posedge clk); #1;
      end
      ack_host();

      // Mode 1: retry, retry, done
      for (int i = 0; i < 3; i++) begin
         issue(1, i, 0, 8'h59, 16'(16'h1000 + i), 68'(64'hA0 + i));
         wait_done();
      end
      check_stats("retry_seq");
      ack_host();

      // Mode 2: pending, ready after the wait, then done on reissue
      issue(2, 1, 10, 8'h5A, 16'h2222, 68'h5555);
      wait_done();
      issue(2, 0, 4, 8'h5B, 16'h2223, 68'h6666);
      wait_done();

      // Host still busy: done becomes busy retry, source untouched
      issue(0, 2, 0, 8'h58, 16'h3333, 68'h7777);
      wait_done();
      check("busy_src_unchanged", bus.host_int_src, 64'h6666);
      ack_host();

      // Bad opcode: flagged, no response
      @(posedge clk); #1;
      bus.afu_cmd_valid = 1'b1; bus.afu_cmd_opcode = 8'h20;
      @(posedge clk); #1 bus.afu_cmd_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1 check("err_bad_opcode_set", 64'(err_bad_opcode), 64'd1);
      check("err_overlap_clear", 64'(err_overlap), 64'd0);

      // Overlapping command during DELAY is dropped
      issue(0, 5, 0, 8'h5B, 16'h4444, 68'h8888);
      bus.afu_cmd_valid = 1'b1; bus.afu_cmd_opcode = 8'h59; bus.afu_cmd_afutag = 16'h9999;
      @(posedge clk); #1 bus.afu_cmd_valid = 1'b0;
      wait_done();
      repeat (10) @(posedge clk);
      #1 check("err_overlap_set", 64'(err_overlap), 64'd1);
      check_stats("after_overlap");
      ack_host();

      // Reset while waiting to send ready: the ready pulse never appears
      issue(2, 1, 10, 8'h5A, 16'h0BEE, 68'hBEEF);
      for (int i = 0; i < 50 && exp_q.size() > 1; i++) @(posedge clk);
      check("pend_first_rsp_seen", 64'(exp_q.size()), 64'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      issue(0, 1, 0, 8'h58, 16'h5A5A, 68'hF00D);
      wait_done();
      check("post_reset_host_src", bus.host_int_src, 64'hF00D);
      ack_host();

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         logic [67:0] obj;
         obj = {4'($urandom), 32'($urandom), 32'($urandom)};
         if ($urandom_range(1, 0) == 1) ack_host();
         issue(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
               int'($urandom_range(12, 0)), 8'(8'h58 + $urandom_range(3, 0)),
               16'($urandom), obj);
         wait_done();
      end
      check_stats("final");
      check("final_err_bad", 64'(err_bad_opcode), 64'd0);
      check("final_err_ovl", 64'(err_overlap), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
